alu_iter: RTL

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle arithmetic/logic ops, shifts and rotates stepped one bit per cycle.
// Valid/ready handshake on both input and output; result and flags held until consumed.
module alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] rhs,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output logic             busy
);
  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_TEST = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_ASR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_ADC  = 4'd12;
  localparam logic [3:0] OP_SBC  = 4'd13;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_zero, r_neg, r_carry, r_ovf, r_err;

  logic             w_accept, w_isShift, w_cin;
  logic [CW-1:0]    w_n;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_aluRes, w_stepRes;
  logic             w_aluCarry, w_aluOvf, w_aluErr, w_stepCarry;

  assign in_ready  = !rst && (r_state == IDLE || (r_state == DONE && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT);
  assign result    = r_result;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign err       = r_err;

  // Single-cycle result from the live inputs; shift ops only use this path when the count is zero.
  always_comb begin
    w_cin      = c_in && (op == OP_ADC || op == OP_SBC);
    w_sum      = {1'b0, accum} + {1'b0, rhs} + {{WIDTH{1'b0}}, w_cin};
    w_diff     = {1'b0, accum} - {1'b0, rhs} - {{WIDTH{1'b0}}, w_cin};
    w_isShift  = (op >= OP_SHL) && (op <= OP_ROR);
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    w_aluOvf   = 1'b0;
    w_aluErr   = 1'b0;
    if (op == OP_ROL || op == OP_ROR)
      w_n = {1'b0, rhs[LW-1:0]};
    else if (|rhs[WIDTH-1:LW])
      w_n = CW'(WIDTH);
    else
      w_n = {1'b0, rhs[LW-1:0]};
    case (op)
      OP_ADD, OP_ADC: begin
        w_aluRes   = w_sum[WIDTH-1:0];
        w_aluCarry = w_sum[WIDTH];
        w_aluOvf   = (accum[WIDTH-1] == rhs[WIDTH-1]) && (w_sum[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        w_aluRes   = w_diff[WIDTH-1:0];
        w_aluCarry = w_diff[WIDTH];
        w_aluOvf   = (accum[WIDTH-1] != rhs[WIDTH-1]) && (w_diff[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_TEST: w_aluRes = accum;
      OP_AND:  w_aluRes = accum & rhs;
      OP_OR:   w_aluRes = accum | rhs;
      OP_XOR:  w_aluRes = accum ^ rhs;
      OP_NOT:  w_aluRes = ~accum;
      OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: w_aluRes = accum;
      default: w_aluErr = 1'b1;
    endcase
  end

  // One-bit move of the work register; carry is the bit that leaves the end.
  always_comb begin
    w_stepRes   = r_result;
    w_stepCarry = 1'b0;
    case (r_op)
      OP_SHL: begin
        w_stepRes   = {r_result[WIDTH-2:0], 1'b0};
        w_stepCarry = r_result[WIDTH-1];
      end
      OP_SHR: begin
        w_stepRes   = {1'b0, r_result[WIDTH-1:1]};
        w_stepCarry = r_result[0];
      end
      OP_ASR: begin
        w_stepRes   = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        w_stepCarry = r_result[0];
      end
      OP_ROL: begin
        w_stepRes   = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
        w_stepCarry = r_result[WIDTH-1];
      end
      OP_ROR: begin
        w_stepRes   = {r_result[0], r_result[WIDTH-1:1]};
        w_stepCarry = r_result[0];
      end
      default: ;
    endcase
  end

  // The result register doubles as the shift work register while in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_result <= w_stepRes;
          r_carry  <= w_stepCarry;
          r_zero   <= (w_stepRes == '0);
          r_neg    <= w_stepRes[WIDTH-1];
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            r_state <= DONE;
        end
        default: begin
          if (w_accept) begin
            r_op <= op;
            if (w_isShift && w_n != '0) begin
              r_result <= accum;
              r_cnt    <= w_n;
              r_carry  <= 1'b0;
              r_zero   <= 1'b0;
              r_neg    <= 1'b0;
              r_ovf    <= 1'b0;
              r_err    <= 1'b0;
              r_state  <= SHIFT;
            end else begin
              r_result <= w_aluRes;
              r_carry  <= w_aluCarry;
              r_ovf    <= w_aluOvf;
              r_err    <= w_aluErr;
              r_zero   <= !w_aluErr && (w_aluRes == '0);
              r_neg    <= w_aluRes[WIDTH-1];
              r_state  <= DONE;
            end
          end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
